// File: rtl/cceip_rbus_pkg.sv
// Shared definitions for the rBUS/APB register responder: register map and handshake states.
package cceip_rbus_pkg;

  localparam int unsigned APB_DATA_W    = 32;

  localparam int unsigned ADDR_ID       = 32'h00;
  localparam int unsigned ADDR_CTRL     = 32'h04;
  localparam int unsigned ADDR_STATUS   = 32'h08;
  localparam int unsigned ADDR_IRQ      = 32'h0C;
  localparam int unsigned ADDR_IRQ_EN   = 32'h10;
  localparam int unsigned ADDR_SCRATCH0 = 32'h20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } apb_resp_state_e;

endpackage

// File: rtl/cceip_apb_reg_responder_if.sv
// APB3 signal bundle between the rBUS driver (master) and a register completer (slave).
interface cceip_apb_reg_responder_if #(
  parameter int unsigned ADDR_W = 20
);
  import cceip_rbus_pkg::*;

  logic [ADDR_W-1:0]     paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_DATA_W-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/cceip_apb_resp_fsm.sv
// APB completer handshake: setup latch, programmable wait states, one-cycle ack, abort on psel drop.
module cceip_apb_resp_fsm
  import cceip_rbus_pkg::*;
#(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  output logic              pready,
  output logic [ADDR_W-1:0] addr_q,
  output logic              write_q,
  output logic [ADDR_W-1:0] dec_addr_c,
  output logic              dec_write_c,
  output logic              wr_commit_c,
  output logic              rd_sample_c
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned LAST_WAIT = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;

  apb_resp_state_e   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              latch_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pready  <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pready  <= (state_d == ACK);
      if (latch_c) begin
        addr_q  <= paddr;
        write_q <= pwrite;
      end
    end
  end

  // Next state; a dropped psel before the ack abandons the transfer with no side effects.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          latch_c = 1'b1;
          cnt_d   = '0;
          state_d = (WAIT_CYCLES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(LAST_WAIT)) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In the setup cycle the latched copy is not loaded yet, so decode the live bus.
  always_comb begin
    dec_addr_c  = (state_q == IDLE) ? paddr  : addr_q;
    dec_write_c = (state_q == IDLE) ? pwrite : write_q;
    rd_sample_c = (state_d == ACK);
    wr_commit_c = (state_q == ACK) && psel && penable && write_q;
  end

endmodule

// File: rtl/cceip_apb_reg_responder.sv
// APB3 completer fronting the kernel-side register bank: ID, CTRL, STATUS, W1C IRQ, IRQ_EN, scratch.
module cceip_apb_reg_responder
  import cceip_rbus_pkg::*;
#(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned N_SCRATCH   = 4,
  parameter logic [31:0] ID_VALUE    = 32'hCCE1_0001
) (
  input  logic                        clk,
  input  logic                        rst_n,
  cceip_apb_reg_responder_if.slave    s_apb,
  output logic [DATA_W-1:0]           ctrl_out,
  input  logic [DATA_W-1:0]           status_in,
  input  logic [DATA_W-1:0]           event_in,
  output logic                        irq
);

  logic              pready_q;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [ADDR_W-1:0] dec_addr_c;
  logic              dec_write_c;
  logic              wr_commit_c;
  logic              rd_sample_c;

  cceip_apb_resp_fsm #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .psel        (s_apb.psel),
    .penable     (s_apb.penable),
    .pwrite      (s_apb.pwrite),
    .paddr       (s_apb.paddr),
    .pready      (pready_q),
    .addr_q      (addr_q),
    .write_q     (write_q),
    .dec_addr_c  (dec_addr_c),
    .dec_write_c (dec_write_c),
    .wr_commit_c (wr_commit_c),
    .rd_sample_c (rd_sample_c)
  );

  logic [DATA_W-1:0] ctrl_q;
  logic [DATA_W-1:0] irq_q;
  logic [DATA_W-1:0] irq_en_q;
  logic [DATA_W-1:0] scratch_q [N_SCRATCH];
  logic [DATA_W-1:0] prdata_q;
  logic              pslverr_q;
  logic              irq_q_out;

  logic              hit_id, hit_ctrl, hit_status, hit_irq, hit_irq_en, hit_scr;
  logic [ADDR_W-1:0] scr_off, scr_word;
  logic              dec_err_c;
  logic [DATA_W-1:0] rd_data_c;
  logic              wr_ok_c;
  logic [DATA_W-1:0] w1c_mask_c;

  // Address decode, error classification and read mux.
  always_comb begin
    hit_id     = (dec_addr_c == ADDR_W'(ADDR_ID));
    hit_ctrl   = (dec_addr_c == ADDR_W'(ADDR_CTRL));
    hit_status = (dec_addr_c == ADDR_W'(ADDR_STATUS));
    hit_irq    = (dec_addr_c == ADDR_W'(ADDR_IRQ));
    hit_irq_en = (dec_addr_c == ADDR_W'(ADDR_IRQ_EN));
    scr_off    = dec_addr_c - ADDR_W'(ADDR_SCRATCH0);
    scr_word   = scr_off >> 2;
    hit_scr    = (dec_addr_c >= ADDR_W'(ADDR_SCRATCH0)) &&
                 (scr_off < ADDR_W'(4 * N_SCRATCH));
    dec_err_c  = (dec_addr_c[1:0] != 2'b00) ||
                 !(hit_id || hit_ctrl || hit_status || hit_irq || hit_irq_en || hit_scr) ||
                 (dec_write_c && (hit_id || hit_status));
    rd_data_c  = '0;
    if (hit_id)     rd_data_c = DATA_W'(ID_VALUE);
    if (hit_ctrl)   rd_data_c = ctrl_q;
    if (hit_status) rd_data_c = status_in;
    if (hit_irq)    rd_data_c = irq_q;
    if (hit_irq_en) rd_data_c = irq_en_q;
    for (int i = 0; i < N_SCRATCH; i++) begin
      if (hit_scr && (scr_word == ADDR_W'(i))) rd_data_c = scratch_q[i];
    end
    wr_ok_c    = wr_commit_c && !dec_err_c;
    w1c_mask_c = (wr_ok_c && hit_irq) ? s_apb.pwdata : '0;
  end

  // Register bank; the IRQ set term is ORed last so an event beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      irq_q     <= '0;
      irq_en_q  <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      irq_q_out <= 1'b0;
      for (int i = 0; i < N_SCRATCH; i++) scratch_q[i] <= '0;
    end else begin
      if (wr_ok_c && hit_ctrl)   ctrl_q   <= s_apb.pwdata;
      if (wr_ok_c && hit_irq_en) irq_en_q <= s_apb.pwdata;
      for (int i = 0; i < N_SCRATCH; i++) begin
        if (wr_ok_c && hit_scr && (scr_word == ADDR_W'(i))) scratch_q[i] <= s_apb.pwdata;
      end
      irq_q     <= (irq_q & ~w1c_mask_c) | event_in;
      irq_q_out <= |(irq_q & irq_en_q);
      prdata_q  <= (rd_sample_c && !dec_write_c && !dec_err_c) ? rd_data_c : '0;
      pslverr_q <= rd_sample_c && dec_err_c;
    end
  end

  assign s_apb.prdata  = prdata_q;
  assign s_apb.pready  = pready_q;
  assign s_apb.pslverr = pslverr_q;
  assign ctrl_out      = ctrl_q;
  assign irq           = irq_q_out;

endmodule
